// File: rtl/sim_halt_ctrl.sv
// Commit-stage simulation-termination controller: RUN -> DRAIN -> HALT with a sticky halt record.
// The halt is reported through the output ports; the harness polls halt_o.
module sim_halt_ctrl #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned DRAIN_MAX  = 16,
  parameter int unsigned IDLE_LIMIT = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic [31:0]      commit_inst,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic             commit_ill,
  input  logic [XLEN-1:0]  gpr_a0,
  input  logic             mem_busy,
  output logic             stall_o,
  output logic             halt_o,
  output logic [1:0]       halt_reason,
  output logic             good_trap,
  output logic [31:0]      exit_code,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [1:0] R_EBREAK  = 2'd0;
  localparam logic [1:0] R_ILLEGAL = 2'd1;
  localparam logic [1:0] R_IDLE    = 2'd2;
  localparam logic [1:0] R_DRAIN   = 2'd3;

  localparam int unsigned IDLE_W  = $clog2(IDLE_LIMIT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t              state;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [XLEN-1:0]     last_pc;

  logic trigger;
  assign trigger = commit_valid & (commit_ill | (commit_inst == EBREAK_INST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      stall_o     <= 1'b0;
      halt_o      <= 1'b0;
      halt_reason <= '0;
      good_trap   <= 1'b0;
      exit_code   <= '0;
      halt_pc     <= '0;
      cycle_cnt   <= '0;
      inst_cnt    <= '0;
      idle_cnt    <= '0;
      drain_cnt   <= '0;
      last_pc     <= '0;
    end else begin
      case (state)
        S_RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (commit_valid) begin
            // A commit always clears the watchdog, even on the cycle it would expire.
            inst_cnt <= inst_cnt + 1'b1;
            last_pc  <= commit_pc;
            idle_cnt <= '0;
            if (trigger) begin
              state       <= S_DRAIN;
              stall_o     <= 1'b1;
              halt_reason <= commit_ill ? R_ILLEGAL : R_EBREAK;
              exit_code   <= gpr_a0[31:0];
              halt_pc     <= commit_pc;
              drain_cnt   <= '0;
            end
          end else if (idle_cnt == IDLE_W'(IDLE_LIMIT - 1)) begin
            state       <= S_HALT;
            stall_o     <= 1'b1;
            halt_o      <= 1'b1;
            halt_reason <= R_IDLE;
            exit_code   <= '0;
            halt_pc     <= last_pc;
            good_trap   <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (!mem_busy) begin
            state     <= S_HALT;
            halt_o    <= 1'b1;
            good_trap <= (halt_reason == R_EBREAK) && (exit_code == '0);
          end else if (drain_cnt == DRAIN_W'(DRAIN_MAX - 1)) begin
            // Drain gave up: the trigger's exit code is kept, only the reason changes.
            state       <= S_HALT;
            halt_o      <= 1'b1;
            halt_reason <= R_DRAIN;
            good_trap   <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        S_HALT: begin
          stall_o <= 1'b1;
          halt_o  <= 1'b1;
        end

        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// Directed testbench for sim_halt_ctrl (IDLE_LIMIT=8, DRAIN_MAX=16).
module tb_sim_halt_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_inst = '0;
  logic [63:0] commit_pc = '0;
  logic        commit_ill = 1'b0;
  logic [63:0] gpr_a0 = '0;
  logic        mem_busy = 1'b0;
  logic        stall_o;
  logic        halt_o;
  logic [1:0]  halt_reason;
  logic        good_trap;
  logic [31:0] exit_code;
  logic [63:0] halt_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] inst_cnt;

  int checks = 0;
  int failures = 0;

  sim_halt_ctrl #(
    .XLEN      (64),
    .CNT_W     (64),
    .DRAIN_MAX (16),
    .IDLE_LIMIT(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .commit_valid(commit_valid),
    .commit_inst (commit_inst),
    .commit_pc   (commit_pc),
    .commit_ill  (commit_ill),
    .gpr_a0      (gpr_a0),
    .mem_busy    (mem_busy),
    .stall_o     (stall_o),
    .halt_o      (halt_o),
    .halt_reason (halt_reason),
    .good_trap   (good_trap),
    .exit_code   (exit_code),
    .halt_pc     (halt_pc),
    .cycle_cnt   (cycle_cnt),
    .inst_cnt    (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic commit(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ill, input logic [63:0] a0);
    commit_valid = v;
    commit_inst  = inst;
    commit_pc    = pc;
    commit_ill   = ill;
    gpr_a0       = a0;
  endtask

  task automatic idle();
    commit(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".stall"}, 64'(stall_o), 64'd0);
    check({tag, ".halt"}, 64'(halt_o), 64'd0);
    check({tag, ".reason"}, 64'(halt_reason), 64'd0);
    check({tag, ".good"}, 64'(good_trap), 64'd0);
    check({tag, ".exit"}, 64'(exit_code), 64'd0);
    check({tag, ".pc"}, halt_pc, 64'd0);
    check({tag, ".cyc"}, cycle_cnt, 64'd0);
    check({tag, ".inst"}, inst_cnt, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle();
    mem_busy = 1'b0;
    #2;
    check_cleared(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: clean EBREAK, a0=0, no outstanding memory traffic
    do_reset("rst1");
    commit(1'b1, NOP, 64'h8000_000c, 1'b0, 64'd0);
    tick(1);
    commit(1'b1, EBREAK, 64'h8000_0010, 1'b0, 64'd0);
    tick(1);
    check("t1.stall_n1", 64'(stall_o), 64'd1);
    check("t1.halt_n1", 64'(halt_o), 64'd0);
    idle();
    tick(1);
    check("t1.halt_n2", 64'(halt_o), 64'd1);
    check("t1.reason", 64'(halt_reason), 64'd0);
    check("t1.good", 64'(good_trap), 64'd1);
    check("t1.pc", halt_pc, 64'h8000_0010);
    check("t1.exit", 64'(exit_code), 64'd0);
    commit(1'b1, NOP, 64'h8000_0014, 1'b0, 64'd9);
    tick(2);
    check("t1.cyc_frozen", cycle_cnt, 64'd3);
    check("t1.inst_frozen", inst_cnt, 64'd2);
    check("t1.pc_stable", halt_pc, 64'h8000_0010);
    check("t1.stall_halt", 64'(stall_o), 64'd1);

    // 2: EBREAK with nonzero upper a0, memory busy for 5 drain cycles
    do_reset("rst2");
    mem_busy = 1'b1;
    commit(1'b1, EBREAK, 64'h8000_0020, 1'b0, 64'h1_0000_0005);
    tick(1);
    commit(1'b1, NOP, 64'h8000_0024, 1'b0, 64'd0);
    tick(5);
    check("t2.halt_busy", 64'(halt_o), 64'd0);
    check("t2.inst_drain", inst_cnt, 64'd1);
    check("t2.exit_kept", 64'(exit_code), 64'd5);
    mem_busy = 1'b0;
    idle();
    tick(1);
    check("t2.halt", 64'(halt_o), 64'd1);
    check("t2.good", 64'(good_trap), 64'd0);
    check("t2.reason", 64'(halt_reason), 64'd0);
    check("t2.pc", halt_pc, 64'h8000_0020);

    // 3: illegal flag on an EBREAK word wins
    do_reset("rst3");
    commit(1'b1, EBREAK, 64'h8000_0030, 1'b1, 64'd0);
    tick(1);
    idle();
    tick(1);
    check("t3.halt", 64'(halt_o), 64'd1);
    check("t3.reason", 64'(halt_reason), 64'd1);
    check("t3.good", 64'(good_trap), 64'd0);

    // 4: memory never drains
    do_reset("rst4");
    mem_busy = 1'b1;
    commit(1'b1, EBREAK, 64'h8000_0040, 1'b0, 64'd3);
    tick(1);
    idle();
    tick(15);
    check("t4.halt_15", 64'(halt_o), 64'd0);
    tick(1);
    check("t4.halt_16", 64'(halt_o), 64'd1);
    check("t4.reason", 64'(halt_reason), 64'd3);
    check("t4.exit", 64'(exit_code), 64'd3);
    check("t4.good", 64'(good_trap), 64'd0);
    mem_busy = 1'b0;

    // 5a: watchdog after last commit
    do_reset("rst5a");
    commit(1'b1, NOP, 64'h8000_0100, 1'b0, 64'd7);
    tick(1);
    idle();
    tick(7);
    check("t5a.halt_7", 64'(halt_o), 64'd0);
    check("t5a.stall_7", 64'(stall_o), 64'd0);
    tick(1);
    check("t5a.halt_8", 64'(halt_o), 64'd1);
    check("t5a.stall_8", 64'(stall_o), 64'd1);
    check("t5a.reason", 64'(halt_reason), 64'd2);
    check("t5a.pc", halt_pc, 64'h8000_0100);
    check("t5a.exit", 64'(exit_code), 64'd0);

    // 5b: commit on the 8th idle cycle resets the watchdog
    do_reset("rst5b");
    commit(1'b1, NOP, 64'h8000_0100, 1'b0, 64'd0);
    tick(1);
    idle();
    tick(7);
    commit(1'b1, NOP, 64'h8000_0104, 1'b0, 64'd0);
    tick(1);
    check("t5b.saved", 64'(halt_o), 64'd0);
    idle();
    tick(7);
    check("t5b.halt_7", 64'(halt_o), 64'd0);
    tick(1);
    check("t5b.halt_8", 64'(halt_o), 64'd1);
    check("t5b.pc", halt_pc, 64'h8000_0104);
    check("t5b.inst", inst_cnt, 64'd2);

    // 5c: no commit ever -> halt_pc 0
    do_reset("rst5c");
    tick(8);
    check("t5c.halt", 64'(halt_o), 64'd1);
    check("t5c.pc", halt_pc, 64'd0);
    check("t5c.cyc", cycle_cnt, 64'd8);

    // 6: async reset in DRAIN, then normal operation resumes
    do_reset("rst6");
    mem_busy = 1'b1;
    commit(1'b1, EBREAK, 64'h8000_0200, 1'b0, 64'd1);
    tick(2);
    check("t6.stall_drain", 64'(stall_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("t6.async");
    idle();
    mem_busy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    commit(1'b1, EBREAK, 64'h8000_0210, 1'b0, 64'd0);
    tick(1);
    idle();
    tick(1);
    check("t6.halt_again", 64'(halt_o), 64'd1);
    check("t6.pc", halt_pc, 64'h8000_0210);
    check("t6.good", 64'(good_trap), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
